// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N-channel button synchroniser, tick-sampled debouncer and press/release pulser.
// Optional hold-to-repeat is built when AUTO_REPEAT_EN is defined.
module button_conditioner #(
  parameter int N_CH         = 5,
  parameter int TICK_DIV     = 1000000,
  parameter int DB_DEPTH     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  btn_in,
  output logic [N_CH-1:0]  btn_level,
  output logic [N_CH-1:0]  btn_pulse,
  output logic [N_CH-1:0]  btn_release,
  output logic             any_pulse,
  output logic [IDX_W-1:0] pulse_idx
);

  localparam int TW = $clog2(TICK_DIV);

  logic [N_CH-1:0]     sync1_q, sync2_q;
  logic [TW-1:0]       tick_cnt_q;
  logic                tick;
  logic [DB_DEPTH-1:0] hist_q [N_CH];
  logic [DB_DEPTH-1:0] hist_d [N_CH];
  logic [N_CH-1:0]     level_q, level_d;
  logic [N_CH-1:0]     pulse_q, pulse_d;
  logic [N_CH-1:0]     release_q, release_d;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_q [N_CH];
  logic [RW-1:0] rep_d [N_CH];
`endif

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    level_d   = level_q;
    pulse_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      hist_d[i] = hist_q[i];
`ifdef AUTO_REPEAT_EN
      rep_d[i] = rep_q[i];
`endif
    end
    if (tick) begin
      for (int i = 0; i < N_CH; i++) begin
        hist_d[i] = {hist_q[i][DB_DEPTH-2:0], sync2_q[i]};
        if (!level_q[i] && (&hist_d[i])) begin
          level_d[i] = 1'b1;
          pulse_d[i] = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d[i] = '0;
`endif
        end else if (level_q[i] && !(|hist_d[i])) begin
          level_d[i]   = 1'b0;
          release_d[i] = 1'b1;
`ifdef AUTO_REPEAT_EN
          rep_d[i] = '0;
`endif
        end
`ifdef AUTO_REPEAT_EN
        // Counter holds held-ticks minus one; after each repeat it rewinds by the rate.
        else if (level_q[i]) begin
          if (rep_q[i] == RW'(REPEAT_DELAY - 1)) begin
            pulse_d[i] = 1'b1;
            rep_d[i]   = RW'(REPEAT_DELAY - REPEAT_RATE);
          end else begin
            rep_d[i] = rep_q[i] + RW'(1);
          end
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
      level_q    <= '0;
      pulse_q    <= '0;
      release_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= '0;
`ifdef AUTO_REPEAT_EN
        rep_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q    <= btn_in;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      release_q  <= release_d;
      for (int i = 0; i < N_CH; i++) begin
        hist_q[i] <= hist_d[i];
`ifdef AUTO_REPEAT_EN
        rep_q[i] <= rep_d[i];
`endif
      end
    end
  end

  always_comb begin
    pulse_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pulse_q[i]) pulse_idx = IDX_W'(i);
    end
  end

  assign any_pulse   = |pulse_q;
  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - Self-checking bench for button_conditioner (model, vector table, corner sequences).
module tb_button_conditioner;

  localparam int N  = 5;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn_in = '0;
  logic [4:0] btn_level, btn_pulse, btn_release;
  logic       any_pulse;
  logic [2:0] pulse_idx;

  button_conditioner #(
    .N_CH(N), .TICK_DIV(TD), .DB_DEPTH(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level), .btn_pulse(btn_pulse),
    .btn_release(btn_release), .any_pulse(any_pulse), .pulse_idx(pulse_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: tick = every TD-th edge since reset, samples are input delayed two edges,
  // a level changes once the latest run of equal samples reaches DB.
  int         cyc;
  logic [4:0] d1, d2;
  logic [4:0] m_lvl, m_pulse, m_rel;
  logic       run_val [5];
  int         run_len [5];
  int         held    [5];

  task automatic model_edge(input logic r, input logic [4:0] b);
    logic s;
    m_pulse = '0;
    m_rel   = '0;
    if (r) begin
      cyc = 0; d1 = '0; d2 = '0; m_lvl = '0;
      for (int c = 0; c < N; c++) begin
        run_val[c] = 1'b0; run_len[c] = DB; held[c] = 0;
      end
    end else begin
      if ((cyc % TD) == TD - 1) begin
        for (int c = 0; c < N; c++) begin
          s = d2[c];
          if (s == run_val[c]) run_len[c]++;
          else begin run_val[c] = s; run_len[c] = 1; end
          if (!m_lvl[c] && run_val[c] && run_len[c] >= DB) begin
            m_lvl[c] = 1'b1; m_pulse[c] = 1'b1; held[c] = 0;
          end else if (m_lvl[c] && !run_val[c] && run_len[c] >= DB) begin
            m_lvl[c] = 1'b0; m_rel[c] = 1'b1; held[c] = 0;
          end else if (m_lvl[c]) begin
            held[c]++;
`ifdef AUTO_REPEAT_EN
            if (held[c] >= RD && ((held[c] - RD) % RR) == 0) m_pulse[c] = 1'b1;
`endif
          end
        end
      end
      d2 = d1;
      d1 = b;
      cyc++;
    end
  endtask

  function automatic logic [2:0] low_idx(input logic [4:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic step(input logic r, input logic [4:0] b);
    @(negedge clk);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    #1;
    model_edge(r, b);
    chk("model", {13'b0, btn_level, btn_pulse, btn_release, any_pulse, pulse_idx},
        {13'b0, m_lvl, m_pulse, m_rel, |m_pulse, low_idx(m_pulse)});
  endtask

  typedef struct {
    logic [4:0] btn;
    int         hold_ticks;
    int         exp_pulses;
    int         exp_rels;
    logic [4:0] exp_first;
    int         exp_idx;
  } vec_t;

  vec_t vecs [6];

`ifdef AUTO_REPEAT_EN
  localparam int REP13 = 4;
`else
  localparam int REP13 = 0;
`endif

  initial begin
    int         k;
    int         pulses, rels, fidx;
    logic [4:0] fmask;
    logic       seen;
    logic [4:0] cur;
    logic       r;

    vecs[0] = '{5'b00100,  5, 1,         1, 5'b00100, 2};
    vecs[1] = '{5'b00001,  2, 0,         0, 5'b00000, 0};
    vecs[2] = '{5'b01010,  4, 2,         2, 5'b01010, 1};
    vecs[3] = '{5'b10000, 13, 1 + REP13, 1, 5'b10000, 4};
    vecs[4] = '{5'b11111,  3, 5,         5, 5'b11111, 0};
    vecs[5] = '{5'b00011,  1, 0,         0, 5'b00000, 0};

    // Reset with all buttons held, then a fresh press on the third tick after release.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'b11111);
      chk("reset_outputs", {btn_level, btn_pulse, btn_release, any_pulse}, 16'h0);
    end
    step(1'b0, 5'b11111);
    chk("post_reset_outputs", {btn_level, btn_pulse, btn_release, any_pulse}, 16'h0);
    k = 1;
    while (!any_pulse && k < 40) begin
      step(1'b0, 5'b11111);
      k++;
    end
    chk("reset_press_latency", k, 12);
    chk("reset_press_mask", btn_pulse, 5'b11111);
    for (int i = 0; i < 32; i++) step(1'b0, 5'b00000);

    for (int v = 0; v < 6; v++) begin
      pulses = 0; rels = 0; fidx = 0; fmask = '0; seen = 1'b0;
      for (int i = 0; i < vecs[v].hold_ticks * TD + 32; i++) begin
        step(1'b0, (i < vecs[v].hold_ticks * TD) ? vecs[v].btn : 5'b00000);
        pulses += $countones(btn_pulse);
        rels   += $countones(btn_release);
        if (any_pulse && !seen) begin
          seen = 1'b1; fmask = btn_pulse; fidx = int'(pulse_idx);
        end
      end
      chk($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
      chk($sformatf("vec%0d_releases", v), rels, vecs[v].exp_rels);
      chk($sformatf("vec%0d_first_mask", v), fmask, vecs[v].exp_first);
      chk($sformatf("vec%0d_first_idx", v), fidx, vecs[v].exp_idx);
    end

    // Reset while ch0 is held: no release, fresh press after reset.
    k = 0;
    while (!btn_level[0] && k < 40) begin
      step(1'b0, 5'b00001);
      k++;
    end
    chk("hold_ch0_level", btn_level[0], 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 5'b00001);
    rels = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 5'b00001);
      rels += $countones(btn_release);
    end
    k = 0;
    do begin
      step(1'b0, 5'b00001);
      rels += $countones(btn_release);
      k++;
    end while (!any_pulse && k < 40);
    chk("midreset_press_latency", k, 12);
    chk("midreset_press_mask", btn_pulse, 5'b00001);
    chk("midreset_no_release", rels, 0);
    for (int i = 0; i < 32; i++) step(1'b0, 5'b00000);

    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) if ($urandom_range(0, 11) == 0) cur[c] = ~cur[c];
      r = ($urandom_range(0, 499) == 0);
      step(r, cur);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
